// File: rtl/cdb_arb.sv
// cdb_arb: shares the common data bus between execution units via per-unit 2-entry FIFOs.
// Fixed lowest-index priority by default; define CDB_ARB_RR_EN for round-robin priority.
module cdb_arb #(
    parameter int NUM_REQ = 3,
    parameter int TAG_W   = 4,
    parameter int DATA_W  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    input  logic [NUM_REQ*5-1:0]       req_rd,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic                       cdb_valid,
    output logic [TAG_W-1:0]           cdb_tag,
    output logic [4:0]                 cdb_rd,
    output logic [DATA_W-1:0]          cdb_data,
    output logic [$clog2(NUM_REQ)-1:0] cdb_src
);
    localparam int SrcW = $clog2(NUM_REQ);
    localparam int EntW = TAG_W + 5 + DATA_W;

    logic [EntW-1:0]    mem_q [NUM_REQ][2];
    logic [NUM_REQ-1:0] wr_ptr_q;
    logic [NUM_REQ-1:0] rd_ptr_q;
    logic [1:0]         cnt_q [NUM_REQ];

    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] nonempty;
    logic               gnt_valid;
    logic [SrcW-1:0]    gnt_idx;
    logic [EntW-1:0]    gnt_ent;

`ifdef CDB_ARB_RR_EN
    logic [SrcW-1:0]    rr_ptr_q;
`endif

    // Ready depends only on the registered count, so a full FIFO never looks ready.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = (cnt_q[i] != 2'd2);
            nonempty[i]  = (cnt_q[i] != 2'd0);
            push[i]      = req_valid[i] && req_ready[i];
        end
    end

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (nonempty[i]) begin
                gnt_valid = 1'b1;
                gnt_idx   = SrcW'(i);
            end
        end
`ifdef CDB_ARB_RR_EN
        // Prefer the lowest non-empty index at or above rr_ptr; otherwise wrap to the lowest.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (nonempty[i] && (SrcW'(i) >= rr_ptr_q)) begin
                gnt_idx = SrcW'(i);
            end
        end
`endif
    end

    always_comb begin
        pop     = '0;
        gnt_ent = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_valid && (gnt_idx == SrcW'(i))) begin
                pop[i]  = 1'b1;
                gnt_ent = mem_q[i][rd_ptr_q[i]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                cnt_q[i] <= 2'd0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push[i]) begin
                    wr_ptr_q[i] <= ~wr_ptr_q[i];
                end
                if (pop[i]) begin
                    rd_ptr_q[i] <= ~rd_ptr_q[i];
                end
                if (push[i] && !pop[i]) begin
                    cnt_q[i] <= cnt_q[i] + 2'd1;
                end else if (pop[i] && !push[i]) begin
                    cnt_q[i] <= cnt_q[i] - 2'd1;
                end
            end
        end
    end

    // Storage needs no reset: the pointers and counts decide what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push[i]) begin
                mem_q[i][wr_ptr_q[i]] <= {req_tag[i*TAG_W +: TAG_W], req_rd[i*5 +: 5],
                                          req_data[i*DATA_W +: DATA_W]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_rd    <= '0;
            cdb_data  <= '0;
            cdb_src   <= '0;
        end else if (flush) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= gnt_valid;
            if (gnt_valid) begin
                {cdb_tag, cdb_rd, cdb_data} <= gnt_ent;
                cdb_src                     <= gnt_idx;
            end
        end
    end

`ifdef CDB_ARB_RR_EN
    // A grant in a flush cycle is discarded, so the pointer holds then.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else if (gnt_valid && !flush) begin
            rr_ptr_q <= (gnt_idx == SrcW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
`endif

endmodule
